// File: rtl/bubble_pkg.sv
// Shared bubble read-out definitions: access encodings, sequencer
// states and default cycle counts also used by the page loader.
package bubble_pkg;

  localparam logic [2:0] ACC_IDLE = 3'b000;
  localparam logic [2:0] ACC_BOOT = 3'b110;
  localparam logic [2:0] ACC_USER = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUF,
    RUN
  } seq_state_e;

  localparam int DEF_CLKDIV       = 48;
  localparam int DEF_BOOT_CYCLES  = 4106;
  localparam int DEF_USER_CYCLES  = 584;
  localparam int DEF_WAIT_TIMEOUT = 65535;

  function automatic logic acc_valid(
    input logic [2:0] t
  );
    return (t == ACC_BOOT) || (t == ACC_USER);
  endfunction

endpackage

// File: rtl/bubble_tick_divider.sv
// Enable-gated modulo-CLKDIV counter; strobes tick on the last count
// and restarts from zero when cleared.
module bubble_tick_divider #(
  parameter int CLKDIV = 48
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLKDIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

  assign tick = en & (cnt == LAST);

endmodule

// File: rtl/bubble_output_sequencer.sv
// Sequences one BOOT/USER bubble read-out: waits for the buffer, then
// emits one read tick per bubble cycle while stepping the cycle number.
module bubble_output_sequencer
  import bubble_pkg::*;
#(
  parameter int CLKDIV       = DEF_CLKDIV,
  parameter int BOOT_CYCLES  = DEF_BOOT_CYCLES,
  parameter int USER_CYCLES  = DEF_USER_CYCLES,
  parameter int WAIT_TIMEOUT = DEF_WAIT_TIMEOUT
) (
  input  logic        MCLK,
  input  logic        RST,
  input  logic        START,
  input  logic [2:0]  REQTYPE,
  input  logic        ABORT,
  input  logic        BUFRDY,
  output logic [2:0]  ACCTYPE,
  output logic [12:0] BOUTCYCLENUM,
  output logic        nBOUTCLKEN,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  localparam logic [12:0] BOOT_LAST = 13'(BOOT_CYCLES - 1);
  localparam logic [12:0] USER_LAST = 13'(USER_CYCLES - 1);
  localparam logic [15:0] TMO_LAST  = 16'(WAIT_TIMEOUT - 1);

  seq_state_e  state;
  seq_state_e  state_d;
  logic [2:0]  acc_d;
  logic [12:0] cyc_d;
  logic [15:0] tmo;
  logic [15:0] tmo_d;
  logic        nclk_d;
  logic        busy_d;
  logic        done_d;
  logic        err_d;
  logic        div_en;
  logic        div_clr;
  logic        div_tick;
  logic [12:0] last_cyc;

  assign last_cyc = (ACCTYPE == ACC_USER) ? USER_LAST : BOOT_LAST;
  assign div_en   = (state == RUN);

  bubble_tick_divider #(
    .CLKDIV(CLKDIV)
  ) u_div (
    .clk (MCLK),
    .rst (RST),
    .en  (div_en),
    .clr (div_clr),
    .tick(div_tick)
  );

  always_comb begin
    state_d = state;
    acc_d   = ACCTYPE;
    cyc_d   = BOUTCYCLENUM;
    tmo_d   = tmo;
    nclk_d  = 1'b1;
    done_d  = 1'b0;
    err_d   = 1'b0;
    div_clr = 1'b0;
    unique case (state)
      IDLE: begin
        if (START && !ABORT) begin
          if (acc_valid(REQTYPE)) begin
            state_d = WAIT_BUF;
            acc_d   = REQTYPE;
            cyc_d   = '0;
            tmo_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WAIT_BUF: begin
        if (ABORT) begin
          state_d = IDLE;
          acc_d   = ACC_IDLE;
          cyc_d   = '0;
        end else if (BUFRDY) begin
          state_d = RUN;
          div_clr = 1'b1;
        end else if (tmo == TMO_LAST) begin
          state_d = IDLE;
          acc_d   = ACC_IDLE;
          cyc_d   = '0;
          err_d   = 1'b1;
        end else if (tmo != 16'hFFFF) begin
          tmo_d = tmo + 16'd1;
        end
      end
      RUN: begin
        // abort wins over a tick due on the same edge
        if (ABORT) begin
          state_d = IDLE;
          acc_d   = ACC_IDLE;
          cyc_d   = '0;
        end else begin
          if (div_tick) begin
            nclk_d = 1'b0;
          end
          if (!nBOUTCLKEN) begin
            if (BOUTCYCLENUM == last_cyc) begin
              state_d = IDLE;
              acc_d   = ACC_IDLE;
              cyc_d   = '0;
              done_d  = 1'b1;
            end else begin
              cyc_d = BOUTCYCLENUM + 13'd1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = ACC_IDLE;
        cyc_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      ACCTYPE      <= ACC_IDLE;
      BOUTCYCLENUM <= '0;
      tmo          <= '0;
      nBOUTCLKEN   <= 1'b1;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      ERR          <= 1'b0;
    end else begin
      state        <= state_d;
      ACCTYPE      <= acc_d;
      BOUTCYCLENUM <= cyc_d;
      tmo          <= tmo_d;
      nBOUTCLKEN   <= nclk_d;
      BUSY         <= busy_d;
      DONE         <= done_d;
      ERR          <= err_d;
    end
  end

endmodule

// File: tb/tb_bubble_output_sequencer.sv
// Scoreboard bench for bubble_output_sequencer: expected ticks, DONE
// and ERR events are queued with their cycle stamps and popped on output.
module tb_bubble_output_sequencer;
  import bubble_pkg::*;

  localparam int CLKDIV = 4;
  localparam int BOOT   = 8;
  localparam int USER   = 5;
  localparam int TMO    = 20;

  logic        MCLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [2:0]  REQTYPE = 3'b000;
  logic        ABORT = 1'b0;
  logic        BUFRDY = 1'b0;
  logic [2:0]  ACCTYPE;
  logic [12:0] BOUTCYCLENUM;
  logic        nBOUTCLKEN;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;

  typedef struct {
    int kind;
    int num;
    int acc;
    int at;
  } ev_t;

  ev_t exp_q[$];

  bubble_output_sequencer #(
    .CLKDIV(CLKDIV),
    .BOOT_CYCLES(BOOT),
    .USER_CYCLES(USER),
    .WAIT_TIMEOUT(TMO)
  ) dut (
    .MCLK(MCLK),
    .RST(RST),
    .START(START),
    .REQTYPE(REQTYPE),
    .ABORT(ABORT),
    .BUFRDY(BUFRDY),
    .ACCTYPE(ACCTYPE),
    .BOUTCYCLENUM(BOUTCYCLENUM),
    .nBOUTCLKEN(nBOUTCLKEN),
    .BUSY(BUSY),
    .DONE(DONE),
    .ERR(ERR)
  );

  always #5 MCLK = ~MCLK;

  always @(posedge MCLK) cyc_cnt <= cyc_cnt + 1;

  task automatic check(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic push_ev(int kind, int num, int acc, int at);
    ev_t e;
    e.kind = kind;
    e.num = num;
    e.acc = acc;
    e.at = at;
    exp_q.push_back(e);
  endtask

  // kind 0 tick, 1 done, 2 err; r is the edge that enters RUN
  task automatic push_run(int acc, int len, int r, int n, bit done);
    for (int k = 0; k < n; k++)
      push_ev(0, k, acc, r + CLKDIV * (k + 1));
    if (done)
      push_ev(1, 0, 0, r + CLKDIV * len + 1);
  endtask

  task automatic observe(int kind, int num, int acc);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_ev: got kind=%0d num=%0d acc=%0d at=%0d",
               kind, num, acc, cyc_cnt);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.num != num || e.acc != acc ||
          e.at != cyc_cnt) begin
        bad++;
        $display("FAIL event: got k=%0d n=%0d a=%0d t=%0d want k=%0d n=%0d a=%0d t=%0d",
                 kind, num, acc, cyc_cnt, e.kind, e.num, e.acc, e.at);
      end
    end
  endtask

  always @(negedge MCLK) begin
    if (!RST) begin
      if (!nBOUTCLKEN)
        observe(0, int'(BOUTCYCLENUM), int'(ACCTYPE));
      if (DONE)
        observe(1, int'(BOUTCYCLENUM), int'(ACCTYPE));
      if (ERR)
        observe(2, int'(BOUTCYCLENUM), int'(ACCTYPE));
    end
  end

  task automatic step();
    @(negedge MCLK);
  endtask

  task automatic wait_drain(string name, int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      step();
      n++;
    end
    step();
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_idle(string name);
    check({name, "_acc"}, int'(ACCTYPE), 0);
    check({name, "_busy"}, int'(BUSY), 0);
    check({name, "_num"}, int'(BOUTCYCLENUM), 0);
  endtask

  task automatic boot_full(string name);
    int r;
    REQTYPE = ACC_BOOT;
    START = 1'b1;
    step();
    START = 1'b0;
    check({name, "_busy"}, int'(BUSY), 1);
    step();
    BUFRDY = 1'b1;
    r = cyc_cnt + 1;
    push_run(ACC_BOOT, BOOT, r, BOOT, 1'b1);
    step();
    BUFRDY = 1'b0;
    wait_drain({name, "_drain"}, 200);
    check_idle(name);
  endtask

  initial begin
    int s;
    int r;
    step();
    check("rst_acc", int'(ACCTYPE), 0);
    check("rst_num", int'(BOUTCYCLENUM), 0);
    check("rst_nclk", int'(nBOUTCLKEN), 1);
    check("rst_busy", int'(BUSY), 0);
    check("rst_done", int'(DONE), 0);
    check("rst_err", int'(ERR), 0);
    RST = 1'b0;
    step();

    boot_full("t1");

    s = cyc_cnt;
    REQTYPE = ACC_USER;
    START = 1'b1;
    BUFRDY = 1'b1;
    push_run(ACC_USER, USER, s + 2, USER, 1'b1);
    step();
    START = 1'b0;
    wait_drain("t2_drain", 200);
    BUFRDY = 1'b0;
    check_idle("t2");

    s = cyc_cnt;
    REQTYPE = 3'b101;
    START = 1'b1;
    push_ev(2, 0, 0, s + 1);
    step();
    START = 1'b0;
    check("t3a_busy", int'(BUSY), 0);
    check("t3a_nclk", int'(nBOUTCLKEN), 1);
    wait_drain("t3a_drain", 20);

    s = cyc_cnt;
    REQTYPE = ACC_BOOT;
    START = 1'b1;
    push_ev(2, 0, 0, s + 1 + TMO);
    step();
    START = 1'b0;
    while (cyc_cnt < s + TMO) step();
    check("t3b_busy_late", int'(BUSY), 1);
    wait_drain("t3b_drain", 100);
    check_idle("t3b");

    s = cyc_cnt;
    REQTYPE = ACC_BOOT;
    START = 1'b1;
    step();
    START = 1'b0;
    BUFRDY = 1'b1;
    r = s + 2;
    push_run(ACC_BOOT, BOOT, r, 2, 1'b0);
    step();
    BUFRDY = 1'b0;
    while (cyc_cnt < r + 11) step();
    check("t4_num_pre", int'(BOUTCYCLENUM), 2);
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;
    check("t4_nclk", int'(nBOUTCLKEN), 1);
    check_idle("t4");
    wait_drain("t4_drain", 20);
    boot_full("t4b");

    s = cyc_cnt;
    REQTYPE = ACC_USER;
    START = 1'b1;
    BUFRDY = 1'b1;
    r = s + 2;
    push_run(ACC_USER, USER, r, 2, 1'b0);
    step();
    START = 1'b0;
    while (cyc_cnt < r + 5) step();
    REQTYPE = ACC_BOOT;
    START = 1'b1;
    step();
    START = 1'b0;
    while (cyc_cnt < r + 9) step();
    check("t5_num_pre", int'(BOUTCYCLENUM), 2);
    check("t5_acc_pre", int'(ACCTYPE), int'(ACC_USER));
    #2;
    RST = 1'b1;
    #1;
    check("t5_rst_acc", int'(ACCTYPE), 0);
    check("t5_rst_num", int'(BOUTCYCLENUM), 0);
    check("t5_rst_nclk", int'(nBOUTCLKEN), 1);
    check("t5_rst_busy", int'(BUSY), 0);
    check("t5_rst_done", int'(DONE), 0);
    check("t5_rst_err", int'(ERR), 0);
    step();
    step();
    BUFRDY = 1'b0;
    RST = 1'b0;
    repeat (10) step();
    check("t5_q_empty", exp_q.size(), 0);
    check_idle("t5_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
